// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// word geometry and the latency counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFS_W = $clog2(WORD_BYTES);
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-wide RAM with synchronous write and registered read (read-first on a
// same-address write). Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: captures a request, waits WAIT_CYCLES,
// then pulses ready (with error for rejected accesses) while stall holds the core.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        stall,
  output logic        error
);

  localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [IDX_W-1:0]   cap_index_reg;
  logic [31:0]        cap_wdata_reg;
  logic               cap_write_reg;
  logic               cap_err_reg;
  logic               ready_reg;
  logic               error_reg;
  logic [31:0]        readdata_reg;

  logic               req;
  logic               err_now;
  logic [31:0]        word_addr;
  logic               ram_we;
  logic [IDX_W-1:0]   ram_index;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;
  logic [31:0]        done_rdata;

  assign req       = memread | memwrite;
  assign word_addr = {{BYTE_OFS_W{1'b0}}, address[31:BYTE_OFS_W]};
  assign err_now   = (address[BYTE_OFS_W-1:0] != '0)
                   | (word_addr >= 32'(DEPTH_WORDS))
                   | (memread & memwrite);

  // The RAM sees the live address while idle so a zero-wait access can
  // commit/read on the capture edge itself; otherwise it sees the captured one.
  always_comb begin
    ram_we    = 1'b0;
    ram_index = cap_index_reg;
    ram_wdata = cap_wdata_reg;
    if (state_reg == IDLE) begin
      ram_index = address[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W];
      ram_wdata = writedata;
      if (ZERO_WAIT) begin
        ram_we = memwrite & ~err_now;
      end
    end else if (state_reg == BUSY) begin
      ram_we = req & cap_write_reg & ~cap_err_reg & (cnt_reg == CNT_W'(1));
    end
    // An access cut short by reset must never reach memory.
    ram_we = ram_we & Reset;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clock(clock),
    .we   (ram_we),
    .index(ram_index),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Value presented during the ready cycle and kept afterwards.
  always_comb begin
    done_rdata = ram_rdata;
    if (cap_err_reg) begin
      done_rdata = '0;
    end else if (cap_write_reg) begin
      done_rdata = readdata_reg;
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cap_index_reg <= '0;
      cap_wdata_reg <= '0;
      cap_write_reg <= 1'b0;
      cap_err_reg   <= 1'b0;
      ready_reg     <= 1'b0;
      error_reg     <= 1'b0;
      readdata_reg  <= '0;
    end else begin
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            cap_index_reg <= address[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W];
            cap_wdata_reg <= writedata;
            cap_write_reg <= memwrite;
            cap_err_reg   <= err_now;
            cnt_reg       <= CNT_W'(WAIT_CYCLES);
            if (ZERO_WAIT) begin
              state_reg <= DONE;
              ready_reg <= 1'b1;
              error_reg <= err_now;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
              state_reg <= DONE;
              ready_reg <= 1'b1;
              error_reg <= cap_err_reg;
            end
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          readdata_reg <= done_rdata;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_reg;
  assign error    = error_reg;
  assign readdata = (state_reg == DONE) ? done_rdata : readdata_reg;
  assign stall    = req & ~ready_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with WAIT_CYCLES=2 and one with 0,
// directed scenarios followed by random traffic against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        stl  [2];
  logic        err  [2];

  int wait_of [2] = '{2, 0};

  // Reference model: per-instance word array, which words are known,
  // and the readdata value the core should currently see.
  logic [31:0] mem_m      [2][DEPTH];
  bit          valid_m    [2][DEPTH];
  logic [31:0] last_rd    [2];
  bit          last_known [2];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clock(clock), .Reset(reset_n), .memread(rd[0]), .memwrite(wr[0]),
    .address(addr[0]), .writedata(wdat[0]), .readdata(rdat[0]),
    .ready(rdy[0]), .stall(stl[0]), .error(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .Reset(reset_n), .memread(rd[1]), .memwrite(wr[1]),
    .address(addr[1]), .writedata(wdat[1]), .readdata(rdat[1]),
    .ready(rdy[1]), .stall(stl[1]), .error(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_cycle(input int u);
    @(posedge clock); #1;
    check("idle_ready", 32'(rdy[u]), 32'd0);
    check("idle_error", 32'(err[u]), 32'd0);
    check("idle_stall", 32'(stl[u]), 32'd0);
    if (last_known[u]) check("idle_readdata", rdat[u], last_rd[u]);
  endtask

  task automatic access(input int u, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    bit          e;
    bit          known;
    bit          got;
    int          idx;
    int          n;
    logic [31:0] exp_rd;
    e   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH)) || (r && w);
    idx = int'(a[9:2]);
    if (e) begin
      exp_rd = 32'd0;
      known  = 1'b1;
    end else if (w) begin
      exp_rd = last_rd[u];
      known  = last_known[u];
    end else begin
      exp_rd = mem_m[u][idx];
      known  = valid_m[u][idx];
    end
    @(posedge clock); #1;
    check("pulse_over", 32'(rdy[u]), 32'd0);
    if (last_known[u]) check("readdata_hold", rdat[u], last_rd[u]);
    rd[u] = r; wr[u] = w; addr[u] = a; wdat[u] = d;
    #1;
    check("stall_capture", 32'(stl[u]), 32'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (rdy[u]) got = 1'b1;
      else check("stall_wait", 32'(stl[u]), 32'd1);
    end
    check("ready_seen", 32'(got), 32'd1);
    check("latency", 32'(n), 32'(wait_of[u] + 1));
    check("error_flag", 32'(err[u]), 32'(e));
    check("stall_ready", 32'(stl[u]), 32'd0);
    if (known) check("readdata", rdat[u], exp_rd);
    $display("unit%0d rd=%0b wr=%0b addr=%h wdata=%h -> err=%0b rdata=%h exp=%h lat=%0d",
             u, r, w, a, d, err[u], rdat[u], exp_rd, n);
    if (!e && w) begin
      mem_m[u][idx]   = d;
      valid_m[u][idx] = 1'b1;
    end
    last_rd[u]    = exp_rd;
    last_known[u] = known;
    @(negedge clock);
    rd[u] = 1'b0;
    wr[u] = 1'b0;
  endtask

  // Store dropped by the core during BUSY: no write, no ready.
  task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = a; wdat[0] = d;
    @(posedge clock); #1;
    check("abort_busy_ready", 32'(rdy[0]), 32'd0);
    check("abort_busy_stall", 32'(stl[0]), 32'd1);
    wr[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("abort_no_ready", 32'(rdy[0]), 32'd0);
    end
    $display("unit0 aborted store addr=%h wdata=%h", a, d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          u;
    int          kind;

    // Reset held with a store pending on both units.
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b1; addr[i] = 32'h40; wdat[i] = 32'hBAD0BAD0;
      last_rd[i] = 32'd0; last_known[i] = 1'b1;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", 32'(rdy[i]), 32'd0);
      check("reset_error", 32'(err[i]), 32'd0);
      check("reset_readdata", rdat[i], 32'd0);
      wr[i] = 1'b0;
    end
    @(negedge clock);
    reset_n = 1'b1;

    // Store then load, both latencies.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    access(1, 1'b0, 1'b1, 32'h0, 32'h12345678);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0);

    // Rejected accesses leave the target word untouched.
    access(0, 1'b0, 1'b1, 32'h8, 32'h08080808);
    access(0, 1'b1, 1'b0, 32'h13, 32'h0);
    access(0, 1'b0, 1'b1, 32'(DEPTH * 4), 32'h5A5A5A5A);
    access(0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0);
    access(1, 1'b0, 1'b1, 32'h8, 32'h80808080);
    access(1, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF);
    access(1, 1'b0, 1'b1, 32'h2, 32'h77777777);
    access(1, 1'b1, 1'b0, 32'h8, 32'h0);

    // Abort during BUSY.
    access(0, 1'b0, 1'b1, 32'h20, 32'h20202020);
    abort_store(32'h20, 32'hAAAA5555);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0);

    // Reset in the middle of a store; zero-wait unit sees a store during reset.
    access(0, 1'b0, 1'b1, 32'h24, 32'h24242424);
    access(1, 1'b0, 1'b1, 32'h30, 32'h11111111);
    @(posedge clock); #1;
    wr[0] = 1'b1; addr[0] = 32'h24; wdat[0] = 32'hFFFF0000;
    @(posedge clock); #1;
    reset_n = 1'b0;
    wr[1] = 1'b1; addr[1] = 32'h30; wdat[1] = 32'hBAD0BAD0;
    #1;
    check("midreset_ready", 32'(rdy[0]), 32'd0);
    check("midreset_readdata", rdat[0], 32'd0);
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midreset_hold_ready", 32'(rdy[i]), 32'd0);
      check("midreset_hold_error", 32'(err[i]), 32'd0);
      check("midreset_hold_readdata", rdat[i], 32'd0);
      wr[i] = 1'b0;
      last_rd[i] = 32'd0;
      last_known[i] = 1'b1;
    end
    @(negedge clock);
    reset_n = 1'b1;
    $display("reset pulse applied during unit0 store to 00000024");
    access(0, 1'b1, 1'b0, 32'h24, 32'h0);
    access(1, 1'b1, 1'b0, 32'h30, 32'h0);

    // Random traffic on both units.
    for (int k = 0; k < 80; k++) begin
      u    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      a    = 32'h40 + 32'(4 * $urandom_range(0, 15));
      d    = $urandom;
      case (kind)
        0: access(u, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), d);
        1: access(u, 1'b0, 1'b1, 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 100)), d);
        2: access(u, 1'b1, 1'b1, a, d);
        3, 4, 5: access(u, 1'b0, 1'b1, a, d);
        default: access(u, 1'b1, 1'b0, a, d);
      endcase
      if ($urandom_range(0, 3) == 0) idle_cycle(u);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
